// File: rtl/asip_ctrl_pkg.sv
// asip_ctrl_pkg: shared encodings for the ASIP control unit
package asip_ctrl_pkg;
  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_SYS = 2'b11} op_e;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  typedef enum logic [2:0] {C_EQ, C_NE, C_LT, C_GE, C_CS, C_CC, C_MI, C_AL} cond_e;
  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT, S_FAULT} state_e;
  localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
  localparam logic [2:0] FUNCT_HALT = 3'b111;
endpackage

// File: rtl/asip_cond_unit.sv
// asip_cond_unit: NZCV flags register and branch condition evaluation
module asip_cond_unit
  import asip_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ALUFlags,
  input  logic [2:0] cond,
  output logic       CondEx
);
  logic n, z, c, v;
  always_ff @(posedge clk) begin
    if (reset) {n, z, c, v} <= 4'b0000;
    else if (load) {n, z, c, v} <= ALUFlags;
  end
  always_comb begin
    CondEx = 1'b1;
    unique case (cond_e'(cond))
      C_EQ: CondEx = z;
      C_NE: CondEx = ~z;
      C_LT: CondEx = n ^ v;
      C_GE: CondEx = ~(n ^ v);
      C_CS: CondEx = c;
      C_CC: CondEx = ~c;
      C_MI: CondEx = n;
      C_AL: CondEx = 1'b1;
    endcase
  end
endmodule

// File: rtl/asip_ctrl_unit.sv
// asip_ctrl_unit: instruction decode, flags, memory handshake sequencing
module asip_ctrl_unit
  import asip_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        Halted,
  output logic        Fault
);
  state_e state, state_next, eff;
  logic [CW-1:0] cnt, cnt_next;
  op_e op;
  logic load, cond_ex, flag_ld, unused;
  assign op = op_e'(Instr[16:15]);
  assign load = Instr[14];
  assign unused = ^{Instr[11:8], Instr[3:0]};
  // While reset is held the decode behaves as in RUN so PCWrite shows the RUN value
  assign eff = reset ? S_RUN : state;
  assign flag_ld = !reset && eff == S_RUN && op == OP_DP;
  asip_cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .load     (flag_ld),
    .ALUFlags (ALUFlags),
    .cond     (Instr[14:12]),
    .CondEx   (cond_ex)
  );
  always_comb begin
    RegSrc = 2'b00;
    RegWrite = 1'b0;
    ImmSrc = IMM_DP;
    ALUSrc = 1'b0;
    ALUControl = ALU_ADD;
    MemtoReg = 1'b0;
    PCSrc = 1'b0;
    MemReq = 1'b0;
    MemWrite = 1'b0;
    PCWrite = 1'b0;
    state_next = eff;
    cnt_next = cnt;
    if (eff == S_RUN || eff == S_MEM_WAIT) begin
      unique case (op)
        OP_DP: begin
          ALUSrc = Instr[12];
          ALUControl = Instr[14:13];
          RegWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc = Instr[7:4] == 4'hF;
        end
        OP_MEM: begin
          MemReq = 1'b1;
          ImmSrc = IMM_MEM;
          ALUSrc = 1'b1;
          RegSrc = {~load, 1'b0};
          MemWrite = ~load;
          MemtoReg = load;
          PCWrite = MemReady;
          RegWrite = MemReady & load;
          state_next = MemReady ? S_RUN : eff == S_RUN ? S_MEM_WAIT : cnt == CW'(TIMEOUT) ? S_FAULT : S_MEM_WAIT;
          cnt_next = MemReady ? '0 : eff == S_RUN ? CW'(1) : cnt + 1'b1;
        end
        OP_BR: begin
          RegSrc = 2'b01;
          ALUSrc = 1'b1;
          ImmSrc = IMM_BR;
          PCWrite = 1'b1;
          PCSrc = cond_ex;
        end
        OP_SYS: begin
          PCWrite = Instr[14:12] != FUNCT_HALT;
          state_next = Instr[14:12] != FUNCT_HALT ? eff : S_HALT;
        end
      endcase
    end
    if (reset) {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc, MemReq, MemWrite} = '0;
  end
  assign Halted = !reset && state == S_HALT;
  assign Fault = !reset && state == S_FAULT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
    end
  end
endmodule

// File: doc/asip_ctrl_unit.md
Name: asip_ctrl_unit

Overview:
- Control unit for the 17-bit ASIP single-cycle datapath. Decodes Instr[16:12] into the datapath control signals: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg and PCSrc.
- Holds the architectural NZCV flags register and evaluates branch conditions.
- Sequences data-memory accesses with a req/ready handshake. Stalls the PC through PCWrite until memory completes, with timeout detection and a halt state.

Parameters:
- TIMEOUT, 255, max MEM_WAIT cycles before entering FAULT.
- CW, 8, width of the wait counter (must satisfy 2^CW > TIMEOUT).

Ports:
- clk  in  1  system clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- Instr  in  17  current instruction
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  data memory completes access this cycle
- RegSrc  out  2  [0]=PC as RA1 (branch), [1]=Instr[7:4] as RA2 (store)
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 DP, 01 memory, 10 branch
- ALUSrc  out  1  1 = immediate SrcB
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
- MemtoReg  out  1  1 = result from ReadData
- PCSrc  out  1  1 = load PC from Result
- MemReq  out  1  data memory request
- MemWrite  out  1  store qualifier, valid with MemReq
- PCWrite  out  1  PC register load enable
- Halted  out  1  HALT state
- Fault  out  1  FAULT state (memory timeout)

Behaviour:
- Encoding of Instr[16:15] (op):
  - 00 DP: [14:13] ALU command, [12] I.
  - 01 MEM: [14] L (1 load, 0 store), [13:12] reserved.
  - 10 BR: [14:12] cond.
  - 11 SYS: [14:12]=111 HALT; any other value is NOP.
- Cond codes: 000 EQ Z; 001 NE !Z; 010 LT N^V; 011 GE !(N^V); 100 CS C; 101 CC !C; 110 MI N; 111 AL.
- FSM states: RUN, MEM_WAIT, HALT, FAULT.
- Reset, including mid-MEM_WAIT:
  - State=RUN, flags=0000, wait counter=0.
  - All outputs 0, except PCWrite, which is the RUN-state decode value.
  - Any pending access is abandoned, with no register write.
- RUN, DP instruction:
  - ALUSrc=I, ImmSrc=00, ALUControl=[14:13], RegWrite=1, PCWrite=1.
  - If Instr[7:4]==4'hF, PCSrc=1.
  - Flags are loaded from ALUFlags at the clock edge.
- RUN, BR instruction:
  - RegSrc[0]=1, ALUSrc=1, ImmSrc=10, ALUControl=00, PCWrite=1.
  - PCSrc = cond evaluated on the registered flags (not on ALUFlags).
  - RegWrite=0; flags are unchanged.
- RUN, MEM instruction:
  - MemReq=1, ImmSrc=01, ALUSrc=1, ALUControl=00.
  - Store: RegSrc[1]=1, MemWrite=1.
  - Load: MemtoReg=1.
  - If MemReady=1 in the same cycle: the access completes. PCWrite=1; RegWrite=1 for loads; state stays RUN.
  - Otherwise: PCWrite=0, RegWrite=0, counter reset to 1, next state MEM_WAIT.
- MEM_WAIT:
  - Same decode outputs as RUN for the instruction; MemReq and MemWrite stay held.
  - When MemReady=1: PCWrite=1, RegWrite=L, next state RUN, counter cleared.
  - Else if counter==TIMEOUT: next state FAULT with MemReq dropped.
  - Else: the counter increments.
  - MemReady takes priority over timeout in the same cycle.
- Memory writes happen exactly once, on the MemReady cycle; the memory samples the store only then.
- RUN, SYS instruction:
  - NOP: PCWrite=1, no writes.
  - HALT: PCWrite=0, next state HALT.
- HALT and FAULT:
  - Sticky until reset.
  - All enables 0 (RegWrite, MemReq, MemWrite, PCWrite).
  - Halted=1 or Fault=1 respectively.
- MemReady outside a MEM access is ignored.
- Flags update only when a DP instruction completes (PCWrite=1).

Decomposition:
- Package asip_ctrl_pkg holds:
  - op enum (OP_DP, OP_MEM, OP_BR, OP_SYS)
  - ALU command constants
  - cond_e enum
  - state_e enum
  - ImmSrc constants
  - HALT funct constant
- Sub-module asip_cond_unit holds the NZCV flags register (clk, reset, load enable, ALUFlags in) and combinational cond evaluation; its output is CondEx.

Test Plan:
- Reset asserted for 2 cycles, then DP ADD R2=R1+R3 (Instr=17'b00_00_0_0001_0010_0011) -> RegWrite=1, ALUControl=00, PCWrite=1; Halted=0 and Fault=0 after reset.
- Flags check:
  - DP SUB with ALUFlags=0100, then BR EQ -> PCSrc=1.
  - Repeat with ALUFlags=0000 -> PCSrc=0.
  - BR AL always gives PCSrc=1; a BR does not alter flags.
- LDR with MemReady low 3 cycles then high -> MemReq=1 for 4 cycles, PCWrite=0/0/0/1, RegWrite=1 only in the 4th cycle, MemtoReg=1 throughout.
- STR with MemReady=1 in the same cycle -> MemReq=MemWrite=1, RegSrc=10, PCWrite=1, RegWrite=0, single-cycle completion.
- Timeout and reset mid-wait:
  - TIMEOUT=4, LDR with MemReady held 0 -> FAULT entered after 4 MEM_WAIT cycles, Fault=1, MemReq=0; state sticky for 10 cycles.
  - Reset -> RUN.
  - Reset during MEM_WAIT -> no RegWrite, RUN next.
- HALT (op=11, funct=111) -> PCWrite=0 immediately, Halted=1 next cycle, subsequent Instr ignored; DP writing R15 -> PCSrc=1.
